// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the streaming matrix multiplier: FSM states,
// accumulator sizing and the OUT_W conversion (saturate or wrap, with overflow detect).
package matrix_stream_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Widest value the conversion helper handles; every ACC_W and OUT_W must stay below it.
    localparam int MAX_W = 128;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } conv_t;

    function automatic int acc_width(input int data_w, input int k);
        return 2 * data_w + $clog2(k + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // full must already be sign- or zero-extended to MAX_W; the caller keeps the low out_w bits.
    function automatic conv_t convert_result(input logic [MAX_W-1:0] full,
                                             input int               out_w,
                                             input bit               is_signed,
                                             input bit               saturate);
        conv_t            r;
        logic [MAX_W-1:0] hi;
        logic [MAX_W-1:0] umax;
        logic [MAX_W-1:0] smax;
        umax = (MAX_W'(1) << out_w) - MAX_W'(1);
        smax = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
        if (is_signed) begin
            // In range exactly when every bit from the OUT_W sign bit upward agrees.
            hi    = $signed(full) >>> (out_w - 1);
            r.ovf = (hi != '0) && (hi != '1);
            if (saturate && r.ovf) begin
                r.val = full[MAX_W-1] ? ~smax : smax;
            end else begin
                r.val = full;
            end
        end else begin
            r.ovf = (full >> out_w) != '0;
            r.val = (saturate && r.ovf) ? umax : full;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_multiply_stream_mac_unit.sv
// Single multiply-accumulate stage: acc <= (clr ? 0 : acc) + a*b at ACC_W width.
// acc_nxt_o is the value being registered, so the caller can capture a finished sum on the same edge.
module mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_nxt_o
);
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_q;

    // Extending before the multiply keeps the low ACC_W product bits exact in both modes.
    assign a_ext     = (SIGNED != 0) ? ACC_W'($signed(a_i)) : ACC_W'(a_i);
    assign b_ext     = (SIGNED != 0) ? ACC_W'($signed(b_i)) : ACC_W'(b_i);
    assign prod      = a_ext * b_ext;
    assign acc_nxt_o = (clr_i ? '0 : acc_q) + prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_nxt_o;
        end
    end

endmodule

// File: rtl/matrix_multiply_stream.sv
// Streams A then B in, runs M*N*K MAC cycles on one shared MAC, then drains C row-major.
// Input stalls on in_valid low; output holds C[idx] stable while out_ready is low.
module matrix_multiply_stream
    import matrix_stream_pkg::*;
#(
    parameter int M        = 2,
    parameter int K        = 2,
    parameter int N        = 2,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);
    localparam int ACC_W = acc_width(DATA_W, K);
    localparam int NA    = M * K;
    localparam int NB    = K * N;
    localparam int NC    = M * N;
    localparam int AIW   = idx_width(NA);
    localparam int BIW   = idx_width(NB);
    localparam int CIW   = idx_width(NC);
    localparam int LW    = (AIW > BIW) ? AIW : BIW;
    localparam int MW    = idx_width(M);
    localparam int KW    = idx_width(K);
    localparam int NW    = idx_width(N);

    state_e          state_q, state_d;
    logic [LW-1:0]   ld_idx_q, ld_idx_d;
    logic [MW-1:0]   i_q, i_d;
    logic [KW-1:0]   k_q, k_d;
    logic [NW-1:0]   j_q, j_d;
    logic [CIW-1:0]  out_idx_q, out_idx_d;
    logic            out_valid_q, out_valid_d;
    logic            ovf_q, ovf_d;
    logic            live_q;

    logic [DATA_W-1:0] a_buf [NA];
    logic [DATA_W-1:0] b_buf [NB];
    logic [OUT_W-1:0]  c_buf [NC];

    logic [AIW-1:0]   a_addr;
    logic [BIW-1:0]   b_addr;
    logic [CIW-1:0]   c_addr;
    logic             in_hs;
    logic             a_we, b_we, c_we, mac_en;
    logic [ACC_W-1:0] acc_nxt;
    logic [MAX_W-1:0] acc_full;
    conv_t            conv;
    logic             unused_conv_hi;

    // live_q keeps in_ready low until the first edge after reset is released.
    assign in_ready  = live_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign in_hs     = in_valid && in_ready;
    assign busy      = (state_q == COMPUTE) || (state_q == DRAIN);
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? c_buf[out_idx_q] : '0;
    assign out_last  = out_valid_q && (out_idx_q == CIW'(NC - 1));
    assign overflow  = ovf_q;

    assign a_addr = AIW'(int'(i_q) * K + int'(k_q));
    assign b_addr = BIW'(int'(k_q) * N + int'(j_q));
    assign c_addr = CIW'(int'(i_q) * N + int'(j_q));

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (mac_en),
        .clr_i     (k_q == '0),
        .a_i       (a_buf[a_addr]),
        .b_i       (b_buf[b_addr]),
        .acc_nxt_o (acc_nxt)
    );

    assign acc_full       = (SIGNED != 0) ? MAX_W'($signed(acc_nxt)) : MAX_W'(acc_nxt);
    assign conv           = convert_result(acc_full, OUT_W, SIGNED != 0, SATURATE != 0);
    assign unused_conv_hi = ^conv.val[MAX_W-1:OUT_W];

    always_comb begin
        state_d     = state_q;
        ld_idx_d    = ld_idx_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        a_we        = 1'b0;
        b_we        = 1'b0;
        c_we        = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (in_hs) begin
                    a_we = 1'b1;
                    // A new set starts: the previous set's overflow no longer applies.
                    if (ld_idx_q == '0) begin
                        ovf_d = 1'b0;
                    end
                    if (ld_idx_q == LW'(NA - 1)) begin
                        ld_idx_d = '0;
                        state_d  = LOAD_B;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    b_we = 1'b1;
                    if (ld_idx_q == LW'(NB - 1)) begin
                        ld_idx_d = '0;
                        i_d      = '0;
                        j_d      = '0;
                        k_d      = '0;
                        state_d  = COMPUTE;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                if (k_q == KW'(K - 1)) begin
                    c_we = 1'b1;
                    if (conv.ovf) begin
                        ovf_d = 1'b1;
                    end
                    k_d = '0;
                    if (j_q == NW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == MW'(M - 1)) begin
                            i_d         = '0;
                            out_idx_d   = '0;
                            out_valid_d = 1'b1;
                            state_d     = DRAIN;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == CIW'(NC - 1)) begin
                        out_idx_d   = '0;
                        out_valid_d = 1'b0;
                        state_d     = LOAD_A;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            ld_idx_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_idx_q    <= ld_idx_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            live_q      <= 1'b1;
        end
    end

    // Operand and result storage needs no reset; stale contents are never presented.
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_buf[AIW'(ld_idx_q)] <= in_data;
        end
        if (b_we) begin
            b_buf[BIW'(ld_idx_q)] <= in_data;
        end
        if (c_we) begin
            c_buf[c_addr] <= conv.val[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_matrix_multiply_stream.sv
// Directed bench: four configurations (2x2x2 wrap, 2x3x1, 2x2x2 saturate, 2x2x2 signed)
// driven from a vector table, plus reset sequences.
module tb_matrix_multiply_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              rst_n;
    logic [3:0]        in_valid, in_ready, out_valid, out_ready, out_last, busy, overflow;
    logic [3:0][15:0]  in_data, out_data;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        int               dut;
        int               na;
        int               nb;
        int               nc;
        int               lat;
        bit               gap;
        bit               bp;
        bit               ovf;
        bit               prev_ovf;
        logic [0:8][15:0] din;
        logic [0:3][15:0] dexp;
    } vec_t;

    vec_t vt [8];

    matrix_multiply_stream #(.M(2), .K(2), .N(2), .DATA_W(16), .OUT_W(16), .SIGNED(0), .SATURATE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .busy(busy[0]), .overflow(overflow[0]));
    matrix_multiply_stream #(.M(2), .K(3), .N(1), .DATA_W(16), .OUT_W(16), .SIGNED(0), .SATURATE(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .busy(busy[1]), .overflow(overflow[1]));
    matrix_multiply_stream #(.M(2), .K(2), .N(2), .DATA_W(16), .OUT_W(16), .SIGNED(0), .SATURATE(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
        .busy(busy[2]), .overflow(overflow[2]));
    matrix_multiply_stream #(.M(2), .K(2), .N(2), .DATA_W(16), .OUT_W(16), .SIGNED(1), .SATURATE(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]), .out_last(out_last[3]),
        .busy(busy[3]), .overflow(overflow[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Streams A then B; returns after the negedge following the last accepting edge.
    task automatic load(input int v, output int t_acc);
        vec_t       t;
        logic [1:0] d;
        int         w;
        t = vt[3'(v)];
        d = 2'(t.dut);
        if (t.prev_ovf) check($sformatf("v%0d ovf_held", v), 32'(overflow[d]), 32'd1);
        for (int e = 0; e < t.na + t.nb; e++) begin
            if (t.gap && (e % 2 == 1)) begin
                in_valid[d] = 1'b0;
                @(negedge clk);
            end
            in_valid[d] = 1'b1;
            in_data[d]  = t.din[4'(e)];
            w = 0;
            while (!in_ready[d] && w < 50) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("v%0d in_ready e%0d", v, e), 32'(in_ready[d]), 32'd1);
            @(negedge clk);
            if (e == 0) check($sformatf("v%0d ovf_clear", v), 32'(overflow[d]), 32'd0);
        end
        in_valid[d] = 1'b0;
        t_acc = cyc;
    endtask

    task automatic run_vec(input int v);
        vec_t       t;
        logic [1:0] d;
        int         t_acc, w, got, ph;
        bit         stalled;
        logic [15:0] held;
        t = vt[3'(v)];
        d = 2'(t.dut);
        load(v, t_acc);
        check($sformatf("v%0d busy", v), 32'(busy[d]), 32'd1);
        w = 0;
        while (!out_valid[d] && w < 200) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("v%0d latency", v), cyc - t_acc, t.lat);
        got = 0; ph = 0; stalled = 0; held = '0; w = 0;
        while (got < t.nc && w < 100) begin
            out_ready[d] = t.bp ? (ph % 3 == 0) : 1'b1;
            ph++;
            if (out_valid[d]) begin
                if (stalled) check($sformatf("v%0d hold%0d", v, got), 32'(out_data[d]), 32'(held));
                if (out_ready[d]) begin
                    check($sformatf("v%0d data%0d", v, got), 32'(out_data[d]), 32'(t.dexp[2'(got)]));
                    check($sformatf("v%0d last%0d", v, got), 32'(out_last[d]), 32'(got == t.nc - 1));
                    got++;
                    stalled = 0;
                end else begin
                    held    = out_data[d];
                    stalled = 1;
                end
            end
            @(negedge clk);
            w++;
        end
        out_ready[d] = 1'b0;
        check($sformatf("v%0d count", v), got, t.nc);
        check($sformatf("v%0d out_valid_end", v), 32'(out_valid[d]), 32'd0);
        check($sformatf("v%0d in_ready_end", v), 32'(in_ready[d]), 32'd1);
        check($sformatf("v%0d overflow", v), 32'(overflow[d]), 32'(t.ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:8][15:0] d1234, dffff, dident, dsgn;
        int               t_acc;
        bit               seen;
        d1234  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
        dffff  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0};
        dident = '{16'd1, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0};
        dsgn   = '{16'hFFFF, 16'd0, 16'd0, 16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
        vt[0] = '{dut:0, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:0, prev_ovf:0, din:d1234,
                  dexp:'{16'd7, 16'd10, 16'd15, 16'd22}};
        vt[1] = '{dut:0, na:4, nb:4, nc:4, lat:8, gap:0, bp:1, ovf:0, prev_ovf:0, din:d1234,
                  dexp:'{16'd7, 16'd10, 16'd15, 16'd22}};
        vt[2] = '{dut:1, na:6, nb:3, nc:2, lat:6, gap:1, bp:0, ovf:0, prev_ovf:0,
                  din:'{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd1, 16'd1, 16'd1},
                  dexp:'{16'd6, 16'd15, 16'd0, 16'd0}};
        vt[3] = '{dut:0, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:1, prev_ovf:0, din:dffff,
                  dexp:'{16'h0002, 16'h0002, 16'h0002, 16'h0002}};
        vt[4] = '{dut:0, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:0, prev_ovf:1, din:dident,
                  dexp:'{16'd1, 16'd0, 16'd0, 16'd1}};
        vt[5] = '{dut:2, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:1, prev_ovf:0, din:dffff,
                  dexp:'{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
        vt[6] = '{dut:2, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:0, prev_ovf:1, din:dident,
                  dexp:'{16'd1, 16'd0, 16'd0, 16'd1}};
        vt[7] = '{dut:3, na:4, nb:4, nc:4, lat:8, gap:0, bp:0, ovf:0, prev_ovf:0, din:dsgn,
                  dexp:'{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC}};

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (3) @(negedge clk);
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  32'(out_data[0]), 32'd0);
        check("rst out_last",  32'(out_last),  32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst overflow",  32'(overflow),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready), 32'hF);

        for (int v = 0; v < 8; v++) run_vec(v);

        // Reset while dut0 is computing: nothing stale may come out afterwards.
        load(0, t_acc);
        repeat (2) @(negedge clk);
        check("midrst busy_before", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst in_ready",  32'(in_ready[0]),  32'd0);
        check("midrst out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst busy",      32'(busy[0]),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst in_ready_after", 32'(in_ready[0]), 32'd1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid[0] || busy[0]) seen = 1;
            @(negedge clk);
        end
        check("midrst no_stale", 32'(seen), 32'd0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
